// File: rtl/adder_arbiter64_pkg.sv
// Shared definitions for the two-requester 64-bit adder arbiter:
// data width, output-register state encoding, requester id type and
// the carry-lookahead helper functions used by the shared adder.
package adder_arbiter64_pkg;

   localparam int DATA_W = 64;

   // Output result register occupancy
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   // Identifies which requester issued an operation
   typedef logic req_id_t;

   localparam req_id_t REQ_ID0 = 1'b0;
   localparam req_id_t REQ_ID1 = 1'b1;

   // Group generate/propagate of a 4-wide slice: {G, P}
   function automatic logic [1:0] gp4(input logic [3:0] g, input logic [3:0] p);
      logic grp_g;
      logic grp_p;
      grp_g = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
      grp_p = &p;
      return {grp_g, grp_p};
   endfunction

   // Lookahead carries out of each position of a 4-wide slice.
   // Bit k of the result is the carry out of position k.
   function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                       input logic cin);
      logic [3:0] c;
      c[0] = g[0] | (p[0] & cin);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
      return c;
   endfunction

endpackage

// File: rtl/adder_arbiter64_cla.sv
// 64-bit three-level carry-lookahead adder: 4-bit groups, 16-bit
// sections and a top-level lookahead across the four sections.
module CLA_adder64bit
   import adder_arbiter64_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              c_i,
   output logic [DATA_W-1:0] s_o,
   output logic              c_o
);

   logic [DATA_W-1:0] bit_g;
   logic [DATA_W-1:0] bit_p;
   logic [DATA_W-1:0] bit_c;   // carry into each bit position
   logic [15:0]       grp_g;
   logic [15:0]       grp_p;
   logic [15:0]       grp_c;   // carry into each 4-bit group
   logic [3:0]        sec_g;
   logic [3:0]        sec_p;
   logic [4:0]        sec_c;   // carry into each 16-bit section, [4] = carry out

   // Per-bit generate/propagate and group/section lookahead terms
   always_comb begin
      logic [1:0] gp;
      gp    = '0;
      bit_g = a_i & b_i;
      bit_p = a_i ^ b_i;
      grp_g = '0;
      grp_p = '0;
      sec_g = '0;
      sec_p = '0;
      for (int j = 0; j < 16; j++) begin
         gp       = gp4(bit_g[4*j +: 4], bit_p[4*j +: 4]);
         grp_g[j] = gp[1];
         grp_p[j] = gp[0];
      end
      for (int k = 0; k < 4; k++) begin
         gp       = gp4(grp_g[4*k +: 4], grp_p[4*k +: 4]);
         sec_g[k] = gp[1];
         sec_p[k] = gp[0];
      end
   end

   // Carry distribution: sections first, then groups, then bits
   always_comb begin
      logic [3:0] cc;
      cc          = '0;
      sec_c       = '0;
      grp_c       = '0;
      bit_c       = '0;
      sec_c[0]    = c_i;
      sec_c[4:1]  = cla4(sec_g, sec_p, c_i);
      for (int k = 0; k < 4; k++) begin
         cc                   = cla4(grp_g[4*k +: 4], grp_p[4*k +: 4], sec_c[k]);
         grp_c[4*k]           = sec_c[k];
         grp_c[4*k+1 +: 3]    = cc[2:0];
      end
      for (int j = 0; j < 16; j++) begin
         cc                   = cla4(bit_g[4*j +: 4], bit_p[4*j +: 4], grp_c[j]);
         bit_c[4*j]           = grp_c[j];
         bit_c[4*j+1 +: 3]    = cc[2:0];
      end
   end

   assign s_o = bit_p ^ bit_c;
   assign c_o = sec_c[4];

endmodule

// File: rtl/adder_arbiter64.sv
// Two requesters share one 64-bit adder. A round-robin arbiter picks
// at most one requester per cycle whenever the single-entry result
// register can take a new result; per-requester saturating counters
// record how many operations each requester has had accepted.
module adder_arbiter64
   import adder_arbiter64_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [DATA_W-1:0] a0,
   input  logic [DATA_W-1:0] b0,
   input  logic [DATA_W-1:0] a1,
   input  logic [DATA_W-1:0] b1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_s,
   output logic              res_cf,
   output logic              res_id,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   out_state_e        state_q;
   logic [DATA_W-1:0] res_s_q;
   logic              res_cf_q;
   req_id_t           res_id_q;
   req_id_t           last_gnt_q;
   logic [CNT_W-1:0]  cnt0_q;
   logic [CNT_W-1:0]  cnt1_q;
   logic [CNT_W-1:0]  cnt0_d;
   logic [CNT_W-1:0]  cnt1_d;

   logic              slot_free;
   logic              any_gnt;
   req_id_t           gnt_id;
   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] add_b;
   logic [DATA_W-1:0] add_s;
   logic              add_cf;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // The result slot can accept when empty or being drained this cycle
   assign slot_free = (state_q == EMPTY) || res_ready;

   // Round-robin arbitration; on contention the requester that was not
   // granted most recently wins. Reset suppresses all grants.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset && slot_free) begin
         if (req0 && req1) begin
            gnt0 = (last_gnt_q == REQ_ID1);
            gnt1 = (last_gnt_q == REQ_ID0);
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign any_gnt = gnt0 | gnt1;
   assign gnt_id  = gnt1 ? REQ_ID1 : REQ_ID0;

   // Operand mux feeding the shared adder from the granted requester
   assign add_a = (gnt_id == REQ_ID1) ? a1 : a0;
   assign add_b = (gnt_id == REQ_ID1) ? b1 : b0;

   CLA_adder64bit u_cla (
      .a_i (add_a),
      .b_i (add_b),
      .c_i (1'b0),
      .s_o (add_s),
      .c_o (add_cf)
   );

   // Output FSM with the result register and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         res_s_q    <= '0;
         res_cf_q   <= 1'b0;
         res_id_q   <= REQ_ID0;
         last_gnt_q <= REQ_ID1;
      end else begin
         if (any_gnt) begin
            res_s_q    <= add_s;
            res_cf_q   <= add_cf;
            res_id_q   <= gnt_id;
            last_gnt_q <= gnt_id;
         end
         case (state_q)
            EMPTY: begin
               if (any_gnt) begin
                  state_q <= FULL;
               end
            end
            FULL: begin
               if (res_ready && !any_gnt) begin
                  state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   // Next values of the per-requester acceptance counters
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (gnt0) begin
         cnt0_d = sat_inc(cnt0_q);
      end
      if (gnt1) begin
         cnt1_d = sat_inc(cnt1_q);
      end
   end

   // Acceptance counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign res_valid = (state_q == FULL);
   assign res_s     = res_s_q;
   assign res_cf    = res_cf_q;
   assign res_id    = res_id_q;
   assign cnt0      = cnt0_q;
   assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_adder_arbiter64.sv
// Bench for adder_arbiter64: a transaction-level model of the shared
// adder slot checked every cycle, plus directed scenarios with
// hand-computed expectations.
module tb_adder_arbiter64;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0, req1;
   logic [63:0]       a0, b0, a1, b1;
   logic              gnt0, gnt1;
   logic              res_valid;
   logic              res_ready;
   logic [63:0]       res_s;
   logic              res_cf;
   logic              res_id;
   logic [CNT_W-1:0]  cnt0, cnt1;

   int nchk  = 0;
   int nfail = 0;
   bit chk_en = 1'b0;

   // Model state
   bit          m_valid;
   logic [64:0] m_sum;
   int          m_id;
   int          m_last;
   int          m_cnt[2];

   logic [63:0] tbl_a[4];
   logic [63:0] tbl_b[4];
   int          seen[4];

   adder_arbiter64 #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .a0        (a0),
      .b0        (b0),
      .a1        (a1),
      .b1        (b1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_s     (res_s),
      .res_cf    (res_cf),
      .res_id    (res_id),
      .cnt0      (cnt0),
      .cnt1      (cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Which requester the rules say wins this cycle: -1 none, 0 or 1
   function automatic int m_winner();
      if (reset) return -1;
      if (m_valid && !res_ready) return -1;
      if (req0 && req1) return (m_last == 0) ? 1 : 0;
      if (req0) return 0;
      if (req1) return 1;
      return -1;
   endfunction

   // Model update at each active edge
   always @(posedge clk) begin
      int w;
      w = m_winner();
      if (reset) begin
         m_valid  = 1'b0;
         m_sum    = '0;
         m_id     = 0;
         m_last   = 1;
         m_cnt[0] = 0;
         m_cnt[1] = 0;
      end else if (w >= 0) begin
         m_sum    = (w == 0) ? ({1'b0, a0} + {1'b0, b0}) : ({1'b0, a1} + {1'b0, b1});
         m_id     = w;
         m_last   = w;
         m_valid  = 1'b1;
         if (m_cnt[w] < CMAX) m_cnt[w] = m_cnt[w] + 1;
      end else if (res_ready) begin
         m_valid = 1'b0;
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      int w;
      if (chk_en) begin
         w = m_winner();
         chk("m_gnt0", gnt0, (w == 0));
         chk("m_gnt1", gnt1, (w == 1));
         chk("m_res_valid", res_valid, m_valid);
         if (m_valid) begin
            chk("m_res_sum", {res_cf, res_s}, m_sum);
            chk("m_res_id", res_id, m_id[0]);
         end else if (m_sum == 65'd0 && m_id == 0 && !reset) begin
            // value after a reset with nothing accepted yet
            chk("m_res_clear", {res_cf, res_s}, 65'd0);
         end
         chk("m_cnt0", cnt0, m_cnt[0][CNT_W-1:0]);
         chk("m_cnt1", cnt1, m_cnt[1][CNT_W-1:0]);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req0 = 0; req1 = 0; res_ready = 0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
   endtask

   task automatic do_reset(input int n);
      reset = 1;
      repeat (n) cyc();
      reset = 0;
   endtask

   initial begin
      tbl_a[0] = 64'h0123_4567_89AB_CDEF; tbl_b[0] = 64'hFEDC_BA98_7654_3210;
      tbl_a[1] = 64'h8000_0000_0000_0000; tbl_b[1] = 64'h8000_0000_0000_0000;
      tbl_a[2] = 64'h0000_0000_FFFF_FFFF; tbl_b[2] = 64'h0000_0000_0000_0001;
      tbl_a[3] = 64'h7FFF_FFFF_FFFF_FFFF; tbl_b[3] = 64'h7FFF_FFFF_FFFF_FFFF;

      idle_inputs();
      reset = 1;
      req0  = 1;                    // pending during reset, must not be granted
      @(posedge clk); #1;
      chk_en = 1'b1;
      at_neg();
      chk("rst_gnt0", gnt0, 1'b0);
      chk("rst_valid", res_valid, 1'b0);
      chk("rst_cnt0", cnt0, '0);
      cyc();

      // Single op: all-ones + 1
      reset = 0;
      a0 = 64'hFFFF_FFFF_FFFF_FFFF; b0 = 64'd1; req0 = 1;
      at_neg();
      chk("single_gnt0", gnt0, 1'b1);
      cyc();
      req0 = 0;
      at_neg();
      chk("single_valid", res_valid, 1'b1);
      chk("single_s", res_s, 64'd0);
      chk("single_cf", res_cf, 1'b1);
      chk("single_id", res_id, 1'b0);

      // Contention after reset: grants alternate 0,1,0,1
      cyc();
      idle_inputs();
      do_reset(2);
      a0 = 64'd10; b0 = 64'd20; a1 = 64'd100; b1 = 64'd200;
      req0 = 1; req1 = 1; res_ready = 1;
      for (int i = 0; i < 4; i++) begin
         at_neg();
         chk("rr_gnt0", gnt0, (i % 2 == 0));
         chk("rr_gnt1", gnt1, (i % 2 == 1));
         if (i > 0) chk("rr_valid", res_valid, 1'b1);
         cyc();
      end
      req0 = 0; req1 = 0;
      at_neg();
      chk("rr_cnt0", cnt0, 4'd2);
      chk("rr_cnt1", cnt1, 4'd2);
      chk("rr_last_s", res_s, 64'd300);

      // Backpressure: hold 5+7 while req1 waits
      cyc();
      res_ready = 0; a0 = 64'd5; b0 = 64'd7; req0 = 1;
      at_neg();
      chk("bp_gnt0", gnt0, 1'b1);
      cyc();
      req0 = 0; a1 = 64'hFFFF_FFFF_0000_0000; b1 = 64'h0000_0001_0000_0000; req1 = 1;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         chk("bp_gnt1_low", gnt1, 1'b0);
         chk("bp_hold_s", res_s, 64'd12);
         cyc();
      end
      res_ready = 1;
      at_neg();
      chk("bp_gnt1", gnt1, 1'b1);
      cyc();
      req1 = 0; res_ready = 0;
      at_neg();
      chk("bp_new_s", res_s, 64'd0);
      chk("bp_new_cf", res_cf, 1'b1);
      chk("bp_new_id", res_id, 1'b1);

      // Drain, then res_ready pulses while empty
      cyc();
      res_ready = 1;
      cyc();
      at_neg();
      chk("drain_valid", res_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         res_ready = (i % 2 == 0);
      end
      at_neg();
      chk("empty_valid", res_valid, 1'b0);

      // Saturation: 20 back-to-back req0 ops over an operand table
      cyc();
      idle_inputs();
      do_reset(1);
      res_ready = 1; req0 = 1;
      for (int i = 0; i < 20; i++) begin
         a0 = tbl_a[i % 4]; b0 = tbl_b[i % 4];
         cyc();
      end
      req0 = 0;
      at_neg();
      chk("sat_cnt0", cnt0, 4'd15);
      chk("sat_cnt1", cnt1, 4'd0);
      // last op used table entry 3: 7FFF..F + 7FFF..F
      chk("sat_last", {res_cf, res_s}, 65'h0_FFFF_FFFF_FFFF_FFFE);

      // Reset while FULL with req1 pending
      cyc();
      res_ready = 0; a0 = 64'd1; b0 = 64'd2; req0 = 1;
      cyc();
      req0 = 0; a1 = 64'd3; b1 = 64'd4; req1 = 1; reset = 1;
      at_neg();
      chk("mr_gnt1", gnt1, 1'b0);
      cyc();
      at_neg();
      chk("mr_valid", res_valid, 1'b0);
      chk("mr_cnt0", cnt0, 4'd0);
      chk("mr_cnt1", cnt1, 4'd0);
      cyc();
      reset = 0; req0 = 1; req1 = 1;
      at_neg();
      chk("mr_first_gnt0", gnt0, 1'b1);
      chk("mr_first_gnt1", gnt1, 1'b0);
      cyc();
      idle_inputs();
      res_ready = 1;
      repeat (3) cyc();

      at_neg();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   // Guard against a stuck run
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adder_arbiter64.md
ADDER_ARBITER64 -- requirements
Module: adder_arbiter64

Interface
REQ-001 Parameter CNT_W, default 16, width of each per-requester grant counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 a0, b0, a1, b1  input  64 each  operands of requester 0 / 1.
REQ-006 gnt0, gnt1  output  1 each  combinational; high in the cycle that requester's operands are accepted.
REQ-007 res_valid  output  1  result register holds an unconsumed result.
REQ-008 res_ready  input  1  consumer accepts the result this cycle.
REQ-009 res_s  output  64  registered sum.
REQ-010 res_cf  output  1  registered carry-out of bit 63.
REQ-011 res_id  output  1  requester that issued the held result.
REQ-012 cnt0, cnt1  output  CNT_W each  accepted-operation counts per requester.

Function
REQ-013 Adder sharing: one 64-bit carry-lookahead adder, carry-in fixed 0; its A/B inputs are muxed from the granted requester.
REQ-014 Accept condition: slot_free = !res_valid || res_ready; no grant when slot_free is low.
REQ-015 Arbitration: at most one of gnt0/gnt1 high per cycle; single requester with slot_free is granted.
REQ-016 Round-robin: both requesting with slot_free -> grant the requester not granted most recently; last_gnt pointer updates only on an actual grant.
REQ-017 Requester protocol: reqN and its operands held stable until gntN; request dropped before gnt is legal, no effect.
REQ-018 Latency: operands accepted in cycle N -> res_valid, res_s, res_cf, res_id valid from cycle N+1.
REQ-019 Result hold: while res_valid && !res_ready, res_s/res_cf/res_id stay constant.
REQ-020 Simultaneous drain and accept: res_valid && res_ready && grant -> register reloads with new result, res_valid stays high (full throughput, one op/cycle).
REQ-021 Drain without accept: res_ready && no grant -> res_valid low next cycle.
REQ-022 Output FSM: states EMPTY (res_valid=0), FULL (res_valid=1); EMPTY->FULL on grant; FULL->EMPTY on res_ready without grant; FULL->FULL otherwise.
REQ-023 Arithmetic: res_s = (a+b) mod 2^64, res_cf = bit 64 of a+b; no overflow flag.
REQ-024 Counters: cntN increments by 1 on each gntN; saturates at 2^CNT_W-1, no wrap.
REQ-025 res_ready while EMPTY is ignored.

Reset
REQ-026 reset high at an edge: res_valid=0, res_s=0, res_cf=0, res_id=0, cnt0=cnt1=0, last_gnt=1 (requester 0 wins first contention).
REQ-027 gnt0/gnt1 forced low in any cycle reset is high; request pending mid-reset is not accepted and must be re-presented.
REQ-028 Reset while FULL discards the held result without a res_ready handshake.

Structure
REQ-029 Shared package holds: output state enum (EMPTY, FULL), DATA_W=64 constant, requester-id type.
REQ-030 One sub-module: CLA_adder64bit instance as the shared adder; arbitration, mux, result register, counters in the top module.

Verification
REQ-031 Single op: req0, a0=0xFFFF_FFFF_FFFF_FFFF, b0=1 -> gnt0 same cycle; next cycle res_valid=1, res_s=0, res_cf=1, res_id=0.
REQ-032 Contention after reset: req0=req1=1 continuous, res_ready=1 -> grants alternate 0,1,0,1; res_valid high every cycle from cycle 2; cnt0=cnt1=2 after 4 grants.
REQ-033 Backpressure: result held with res_ready=0 for 5 cycles, req1 asserted -> gnt1 low, res_s constant; res_ready=1 -> gnt1 same cycle, new result next cycle.
REQ-034 Drain: FULL, res_ready=1, no requests -> res_valid=0 next cycle; res_ready pulses in EMPTY change nothing.
REQ-035 Saturation: CNT_W=4, 20 req0 ops -> cnt0 stops at 15.
REQ-036 Reset mid-operation: reset asserted while FULL with req1 pending -> gnt1 low, res_valid=0, counters 0; after release, req0 and req1 together -> gnt0 first.
